// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin bus arbiter with hold timeout and registered grants.
module bus_arbiter #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic breq1,
   input  logic breq2,
   output logic bgrant1,
   output logic bgrant2,
   output logic msel,
   output logic bbusy
);
   typedef enum logic [1:0] {IDLE, GNT1, GNT2, TURN} state_t;
   localparam logic [7:0] CMAX = 8'(TIMEOUT - 1);
   state_t state, nxt;
   logic last_grant;
   logic [7:0] cnt;
   logic own, other, entry, in_gnt;
   always_comb begin
      own = (state == GNT1) ? breq1 : breq2;
      other = (state == GNT1) ? breq2 : breq1;
      in_gnt = (state == GNT1) || (state == GNT2);
      nxt = IDLE;
      case (state)
         IDLE: nxt = (breq1 && breq2) ? (last_grant ? GNT1 : GNT2) : breq1 ? GNT1 : breq2 ? GNT2 : IDLE;
         GNT1, GNT2: nxt = (!own || (cnt == CMAX && other)) ? TURN : state;
         default: nxt = IDLE;
      endcase
      entry = (state == IDLE) && (nxt != IDLE);
   end
   // last_grant: 0 = master 1 served last, 1 = master 2 served last
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         bgrant1 <= 1'b0;
         bgrant2 <= 1'b0;
         msel <= 1'b0;
         bbusy <= 1'b0;
         cnt <= 8'd0;
         last_grant <= 1'b1;
      end else begin
         state <= nxt;
         bgrant1 <= nxt == GNT1;
         bgrant2 <= nxt == GNT2;
         bbusy <= (nxt == GNT1) || (nxt == GNT2);
         if (entry) begin
            cnt <= 8'd0;
            last_grant <= nxt == GNT2;
            msel <= nxt == GNT2;
         end else if (in_gnt) begin
            cnt <= (cnt == CMAX) ? cnt : cnt + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random stimulus against an owner/cooldown reference model.
module tb_bus_arbiter;
   localparam int TIMEOUT = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic breq1 = 1'b0;
   logic breq2 = 1'b0;
   logic bgrant1, bgrant2, msel, bbusy;
   int checks = 0;
   int errors = 0;
   int owner = 0;
   int gap = 0;
   int held = 0;
   int last = 2;
   logic msel_m = 1'b0;
   int n;

   bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .breq1(breq1), .breq2(breq2),
      .bgrant1(bgrant1), .bgrant2(bgrant2), .msel(msel), .bbusy(bbusy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // owner = master holding the bus, gap = cooldown cycles left after a release
   task automatic model_step();
      logic own_r, oth_r;
      own_r = (owner == 1) ? breq1 : breq2;
      oth_r = (owner == 1) ? breq2 : breq1;
      if (rst) begin
         owner = 0; gap = 0; held = 0; last = 2; msel_m = 1'b0;
      end else if (owner != 0) begin
         if (!own_r || (held + 1 >= TIMEOUT && oth_r)) begin
            owner = 0; gap = 1;
         end else held++;
      end else if (gap > 0) gap--;
      else if (breq1 || breq2) begin
         owner = (breq1 && breq2) ? 3 - last : (breq1 ? 1 : 2);
         last = owner; held = 0; msel_m = (owner == 2);
      end
   endtask

   task automatic cyc(input int k);
      for (int i = 0; i < k; i++) begin
         @(posedge clk);
         model_step();
         #1;
         chk("bgrant1", bgrant1, owner == 1);
         chk("bgrant2", bgrant2, owner == 2);
         chk("msel", msel, msel_m);
         chk("bbusy", bbusy, owner != 0);
         chk("mutex", bgrant1 & bgrant2, 1'b0);
      end
   endtask

   initial begin
      rst = 1; cyc(3);
      chk("reset_busy", bbusy, 1'b0);
      rst = 0; cyc(2);
      breq1 = 1; cyc(1);
      chk("single_grant", bgrant1, 1'b1);
      cyc(5);
      breq1 = 0; cyc(1);
      chk("single_release", bgrant1, 1'b0);
      cyc(3);
      rst = 1; cyc(1); rst = 0;
      breq1 = 1; breq2 = 1; cyc(1);
      chk("first_sim_m1", bgrant1, 1'b1);
      cyc(2);
      breq1 = 0; cyc(2);
      chk("turn_gap", bgrant2, 1'b0);
      cyc(1);
      chk("m2_after_turn", bgrant2, 1'b1);
      chk("m2_msel", msel, 1'b1);
      for (int g = 0; g < 8; g++) begin
         breq1 = 1; breq2 = 1;
         cyc(5);
         if (bgrant1) breq1 = 0; else breq2 = 0;
         cyc(3);
      end
      breq1 = 0; breq2 = 0;
      rst = 1; cyc(1); rst = 0;
      breq1 = 1; cyc(1);
      breq2 = 1; n = 1;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (bgrant1) n++; else break;
      end
      chk("timeout_len", n == TIMEOUT, 1'b1);
      cyc(1);
      chk("timeout_idle", bgrant2, 1'b0);
      cyc(1);
      chk("timeout_m2", bgrant2, 1'b1);
      breq1 = 0; breq2 = 0; cyc(3);
      breq1 = 1; cyc(1);
      for (int i = 0; i < 100; i++) begin
         cyc(1);
         chk("alone_hold", bgrant1, 1'b1);
      end
      breq1 = 0; cyc(3);
      breq2 = 1; cyc(3);
      chk("pre_rst_g2", bgrant2, 1'b1);
      rst = 1; cyc(1);
      chk("rst_g2", bgrant2, 1'b0);
      chk("rst_msel", msel, 1'b0);
      rst = 0; cyc(1);
      chk("rearb_g2", bgrant2, 1'b1);
      breq2 = 0; cyc(3);
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         if (owner == 1) breq1 = ($urandom_range(0, 7) != 0);
         else if (breq1) breq1 = ($urandom_range(0, 31) != 0);
         else breq1 = ($urandom_range(0, 3) == 0);
         if (owner == 2) breq2 = ($urandom_range(0, 7) != 0);
         else if (breq2) breq2 = ($urandom_range(0, 31) != 0);
         else breq2 = ($urandom_range(0, 3) == 0);
         cyc(1);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
